// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART SAT-IP: parity selection, FSM state
// encodings and a frame-length helper used to size bit counters.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic int frame_bits(input int data_bits, input parity_e parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count. FULL_PASS lets a
// push into a full FIFO succeed when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit FULL_PASS = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || (FULL_PASS && do_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Empty FIFO presents zero so the head never shows stale or uninitialised data.
  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_sat_fifo.sv
// UART SAT-IP: TX/RX byte FIFOs around a configurable-frame UART with input
// synchronisers, false-start rejection, sticky line errors and RTS flow control.
module uart_sat_fifo import uart_pkg::*; #(
  parameter int      BAUD_DIV   = 217,
  parameter int      DATA_BITS  = 8,
  parameter parity_e PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      TX_DEPTH   = 4,
  parameter int      RX_DEPTH   = 4,
  parameter int      RTS_MARGIN = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_level,
  output logic                          tx_idle,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_overrun,
  input  logic                          err_clr,
  output logic                          UART_TX,
  input  logic                          UART_RX,
  input  logic                          UART_CTS,
  output logic                          UART_RTS
);
  localparam int BW    = $clog2(BAUD_DIV);
  localparam int IDX_W = $clog2(frame_bits(DATA_BITS, PARITY, STOP_BITS));
  localparam int HALF  = BAUD_DIV / 2;

  logic [1:0] rx_sync_q, cts_sync_q;
  logic       rx_prev_q, rx_s, cts_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q  <= 2'b11;
      cts_sync_q <= 2'b11;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], UART_RX};
      cts_sync_q <= {cts_sync_q[0], UART_CTS};
      rx_prev_q  <= rx_s;
    end
  end
  assign rx_s  = rx_sync_q[1];
  assign cts_s = cts_sync_q[1];

  logic [DATA_BITS-1:0] tx_head, rx_shift_q, rx_shift_d;
  logic                 tx_pop, tx_empty, tx_full, rx_push, rx_full, rx_empty;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH), .FULL_PASS(1'b0)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_valid), .data_i(tx_data), .pop_i(tx_pop),
    .head_o(tx_head), .count_o(tx_level), .full_o(tx_full), .empty_o(tx_empty)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH), .FULL_PASS(1'b1)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .data_i(rx_shift_q), .pop_i(rx_ready),
    .head_o(rx_data), .count_o(rx_level), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  tx_state_e            tx_state_q, tx_state_d;
  logic [BW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, tx_line_q, tx_line_d, tx_tick, tx_go;

  assign tx_go = !tx_empty && !cts_s;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_tick    = (tx_cnt_q == BW'(BAUD_DIV-1));
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: if (tx_go) begin
        tx_pop     = 1'b1;
        tx_state_d = TX_START;
        tx_cnt_d   = '0;
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = '0;
      end
      TX_DATA: if (tx_tick) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_idx_q == IDX_W'(DATA_BITS-1)) begin
          tx_state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
          tx_idx_d   = '0;
        end else begin
          tx_idx_d = tx_idx_q + 1'b1;
        end
      end
      TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
      TX_STOP: if (tx_tick) begin
        if (tx_idx_q == IDX_W'(STOP_BITS-1)) begin
          // Chain straight into the next start bit so queued frames have no gap.
          tx_state_d = tx_go ? TX_START : TX_IDLE;
          tx_pop     = tx_go;
        end else begin
          tx_idx_d = tx_idx_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_pop) begin
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ (PARITY == PAR_ODD);
    end
  end

  always_comb begin
    tx_line_d = 1'b1;
    case (tx_state_q)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shift_q[0];
      TX_PARITY: tx_line_d = tx_par_q;
      default:   tx_line_d = 1'b1;
    endcase
  end

  rx_state_e        rx_state_q, rx_state_d;
  logic [BW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
  logic             rx_par_q, rx_par_d, rx_tick, par_bad;
  logic             set_parity, set_frame, set_overrun;

  assign par_bad = (PARITY != PAR_NONE) && (rx_par_q != ((^rx_shift_q) ^ (PARITY == PAR_ODD)));

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_par_d    = rx_par_q;
    rx_push     = 1'b0;
    set_parity  = 1'b0;
    set_frame   = 1'b0;
    set_overrun = 1'b0;
    // Start bit is checked at its middle; every later sample is one full bit on.
    rx_tick = (rx_state_q == RX_START) ? (rx_cnt_q == BW'(HALF-1)) : (rx_cnt_q == BW'(BAUD_DIV-1));
    if (rx_state_q != RX_IDLE) rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: if (rx_tick) begin
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        rx_idx_d   = '0;
      end
      RX_DATA: if (rx_tick) begin
        rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
        if (rx_idx_q == IDX_W'(DATA_BITS-1)) begin
          rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
        end else begin
          rx_idx_d = rx_idx_q + 1'b1;
        end
      end
      RX_PARITY: if (rx_tick) begin
        rx_par_d   = rx_s;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_state_d = RX_IDLE;
        if (!rx_s)                    set_frame   = 1'b1;
        else if (par_bad)             set_parity  = 1'b1;
        else if (rx_full && !rx_ready) set_overrun = 1'b1;
        else                          rx_push     = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_line_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_par_q    <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
      UART_RTS    <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_line_q   <= tx_line_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_par_q    <= rx_par_d;
      err_parity  <= set_parity  | (err_parity  & ~err_clr);
      err_frame   <= set_frame   | (err_frame   & ~err_clr);
      err_overrun <= set_overrun | (err_overrun & ~err_clr);
      UART_RTS    <= (RX_DEPTH - int'(rx_level)) < RTS_MARGIN;
    end
  end

  assign UART_TX = tx_line_q;
  assign tx_idle = tx_empty && (tx_state_q == TX_IDLE);

endmodule

// File: tb/tb_uart_sat_fifo.sv
// Directed bench: instance A is 8N1, instance B is 8E1, both BAUD_DIV=4 with
// TX looped to RX unless a test drives the RX line directly.
module tb_uart_sat_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, err_clr;
  logic [7:0] a_tx_data, b_tx_data, a_rx_data, b_rx_data;
  logic a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready, a_rx_valid, b_rx_valid;
  logic a_rx_ready, b_rx_ready, a_tx_idle, b_tx_idle;
  logic [2:0] a_tx_level, b_tx_level, a_rx_level, b_rx_level;
  logic a_err_par, b_err_par, a_err_frm, b_err_frm, a_err_ovr, b_err_ovr;
  logic a_txd, b_txd, a_rxd, b_rxd, a_rx_drv, b_rx_drv, a_loop, b_loop;
  logic a_cts, b_cts, a_rts, b_rts;

  assign a_rxd = a_loop ? a_txd : a_rx_drv;
  assign b_rxd = b_loop ? b_txd : b_rx_drv;

  uart_sat_fifo #(.BAUD_DIV(4), .PARITY(PAR_NONE)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .tx_level(a_tx_level), .rx_level(a_rx_level), .tx_idle(a_tx_idle),
    .err_parity(a_err_par), .err_frame(a_err_frm), .err_overrun(a_err_ovr), .err_clr(err_clr),
    .UART_TX(a_txd), .UART_RX(a_rxd), .UART_CTS(a_cts), .UART_RTS(a_rts)
  );

  uart_sat_fifo #(.BAUD_DIV(4), .PARITY(PAR_EVEN)) u_b (
    .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .tx_level(b_tx_level), .rx_level(b_rx_level), .tx_idle(b_tx_idle),
    .err_parity(b_err_par), .err_frame(b_err_frm), .err_overrun(b_err_ovr), .err_clr(err_clr),
    .UART_TX(b_txd), .UART_RX(b_rxd), .UART_CTS(b_cts), .UART_RTS(b_rts)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic txd(input bit s);
    return s ? b_txd : a_txd;
  endfunction

  function automatic logic [11:0] mkframe(input logic [7:0] d, input bit par);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par) f[9] = ^d;
    return f;
  endfunction

  task automatic push(input bit s, input logic [7:0] d);
    int k = 0;
    if (s) begin b_tx_data = d; b_tx_valid = 1'b1; end
    else   begin a_tx_data = d; a_tx_valid = 1'b1; end
    while (((s ? b_tx_ready : a_tx_ready) !== 1'b1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("push_ready", s ? b_tx_ready : a_tx_ready, 1);
    @(negedge clk);
    a_tx_valid = 1'b0;
    b_tx_valid = 1'b0;
    $display("push inst=%0d data=%02h", s, d);
  endtask

  task automatic wait_low(input bit s, input string tag);
    int k = 0;
    while (txd(s) !== 1'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(tag, txd(s), 0);
  endtask

  task automatic wait_rxv(input bit s, input string tag);
    int k = 0;
    while ((s ? b_rx_valid : a_rx_valid) !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(tag, s ? b_rx_valid : a_rx_valid, 1);
  endtask

  // Called on the first cycle of a start bit; returns on the cycle after the frame.
  task automatic capture(input bit s, input logic [11:0] f, input int nb, input string tag);
    for (int i = 0; i < nb * 4; i++) begin
      if (i % 4 == 1) chk($sformatf("%s_bit%0d", tag, i / 4), txd(s), f[i / 4]);
      @(negedge clk);
    end
    $display("frame %s inst=%0d bits=%03h", tag, s, f);
  endtask

  task automatic drive_frame(input bit s, input logic [11:0] f, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (s) b_rx_drv = f[i]; else a_rx_drv = f[i];
      repeat (4) @(negedge clk);
    end
    a_rx_drv = 1'b1;
    b_rx_drv = 1'b1;
  endtask

  task automatic pop(input bit s, input logic [7:0] exp, input string tag);
    chk({tag, "_valid"}, s ? b_rx_valid : a_rx_valid, 1);
    chk(tag, s ? b_rx_data : a_rx_data, exp);
    if (s) b_rx_ready = 1'b1; else a_rx_ready = 1'b1;
    @(negedge clk);
    a_rx_ready = 1'b0;
    b_rx_ready = 1'b0;
    $display("pop inst=%0d expected=%02h", s, exp);
  endtask

  task automatic wait_level(input logic [2:0] lvl, input string tag);
    int k = 0;
    while (a_rx_level !== lvl && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, a_rx_level, lvl);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] f;
    int lows;
    rst = 1'b1; err_clr = 1'b0;
    a_tx_data = '0; b_tx_data = '0; a_tx_valid = 1'b0; b_tx_valid = 1'b0;
    a_rx_ready = 1'b0; b_rx_ready = 1'b0; a_rx_drv = 1'b1; b_rx_drv = 1'b1;
    a_loop = 1'b1; b_loop = 1'b1; a_cts = 1'b0; b_cts = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_tx", a_txd, 1);
    chk("rst_rts", a_rts, 1);
    chk("rst_rx_valid", a_rx_valid, 0);
    chk("rst_rx_data", a_rx_data, 0);
    chk("rst_tx_ready", a_tx_ready, 1);
    chk("rst_levels", {a_tx_level, a_rx_level}, 0);
    chk("rst_tx_idle", a_tx_idle, 1);
    chk("rst_errs", {a_err_par, a_err_frm, a_err_ovr}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rts_empty", a_rts, 0);

    // 8N1 latency, frame shape and loopback
    a_tx_data = 8'hA5; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    @(negedge clk);
    chk("t1_lat1", a_txd, 1);
    @(negedge clk);
    chk("t1_lat2", a_txd, 0);
    capture(0, mkframe(8'hA5, 0), 10, "t1");
    chk("t1_idle_after40", a_txd, 1);
    wait_rxv(0, "t1_rxv");
    chk("t1_errs", {a_err_par, a_err_frm, a_err_ovr}, 0);
    pop(0, 8'hA5, "t1_rx");

    // 8E1: parity bit on the wire, then a corrupted parity bit
    push(1, 8'h07);
    wait_low(1, "t2_start");
    capture(1, 12'b1110_0000_1110, 11, "t2");
    wait_rxv(1, "t2_rxv");
    pop(1, 8'h07, "t2_rx");
    b_loop = 1'b0;
    f = mkframe(8'h07, 1);
    f[9] = ~f[9];
    drive_frame(1, f, 11);
    repeat (8) @(negedge clk);
    chk("t2_err_parity", b_err_par, 1);
    chk("t2_rx_level", b_rx_level, 0);
    chk("t2_err_frame", b_err_frm, 0);
    b_loop = 1'b1;

    // Low stop bit, then error clear
    a_loop = 1'b0;
    f = mkframe(8'h3C, 0);
    f[9] = 1'b0;
    drive_frame(0, f, 10);
    repeat (8) @(negedge clk);
    chk("t3_err_frame", a_err_frm, 1);
    chk("t3_rx_level", a_rx_level, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t3_clr_a", {a_err_par, a_err_frm, a_err_ovr}, 0);
    chk("t3_clr_b", b_err_par, 0);
    a_loop = 1'b1;

    // Fill RX FIFO: RTS at 4 entries, overrun on the 5th
    for (int i = 1; i <= 5; i++) push(0, 8'(i * 8'h11));
    wait_level(3'd3, "t4_level3");
    repeat (2) @(negedge clk);
    chk("t4_rts_lvl3", a_rts, 0);
    wait_level(3'd4, "t4_level4");
    repeat (2) @(negedge clk);
    chk("t4_rts_lvl4", a_rts, 1);
    begin
      int k = 0;
      while (a_err_ovr !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t4_overrun", a_err_ovr, 1);
    repeat (4) @(negedge clk);
    chk("t4_level_after", a_rx_level, 4);
    chk("t4_tx_idle", a_tx_idle, 1);
    for (int i = 1; i <= 4; i++) pop(0, 8'(i * 8'h11), $sformatf("t4_pop%0d", i));
    chk("t4_empty", a_rx_valid, 0);

    // CTS hold-off, then three contiguous frames
    a_cts = 1'b1;
    repeat (3) @(negedge clk);
    push(0, 8'h66);
    push(0, 8'h77);
    push(0, 8'h88);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_txd !== 1'b1) lows++;
    end
    chk("t5_hold_lows", lows, 0);
    chk("t5_tx_level", a_tx_level, 3);
    a_cts = 1'b0;
    wait_low(0, "t5_start");
    capture(0, mkframe(8'h66, 0), 10, "t5a");
    capture(0, mkframe(8'h77, 0), 10, "t5b");
    capture(0, mkframe(8'h88, 0), 10, "t5c");
    chk("t5_tx_idle", a_tx_idle, 1);
    chk("t5_line_idle", a_txd, 1);
    repeat (10) @(negedge clk);
    chk("t5_rx_level", a_rx_level, 3);

    // One-cycle RX glitch, then reset mid-frame
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    a_loop = 1'b0;
    a_rx_drv = 1'b0;
    @(negedge clk);
    a_rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_glitch_level", a_rx_level, 3);
    chk("t6_glitch_errs", {a_err_par, a_err_frm, a_err_ovr}, 0);
    a_loop = 1'b1;
    push(0, 8'h5A);
    wait_low(0, "t6_start");
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tx", a_txd, 1);
    chk("t6_rst_levels", {a_tx_level, a_rx_level}, 0);
    chk("t6_rst_rx_valid", a_rx_valid, 0);
    chk("t6_rst_tx_idle", a_tx_idle, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("t6_no_partial", a_rx_level, 0);
    chk("t6_line_idle", a_txd, 1);
    chk("t6_no_err", {a_err_par, a_err_frm, a_err_ovr}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
